// File: rtl/pc_fetch_unit_if.sv
// Control inputs and status outputs of the program-counter / fetch stage.
// No latency of its own; it only bundles the signals.
// No backpressure: stall is the only hold mechanism and is sampled every cycle.
interface pc_fetch_unit_if #(
    parameter int PC_WIDTH  = 5,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 stall;
    logic                 halt_req;
    logic                 jump_en;
    logic [PC_WIDTH-1:0]  jump_target;
    logic                 branch_en;
    logic [15:0]          branch_off;
    logic [PC_WIDTH-1:0]  direinstru;
    logic [PC_WIDTH-1:0]  pc_plus1;
    logic                 running;
    logic                 halted;
    logic                 wrapped;
    logic [CNT_WIDTH-1:0] retired;

    // Sequencer / bench side: drives control, observes status.
    modport master (
        output start, stall, halt_req, jump_en, jump_target, branch_en, branch_off,
        input  direinstru, pc_plus1, running, halted, wrapped, retired
    );

    // Fetch unit side.
    modport slave (
        input  start, stall, halt_req, jump_en, jump_target, branch_en, branch_off,
        output direinstru, pc_plus1, running, halted, wrapped, retired
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding a combinational instruction memory.
// Latency: controls sampled at edge N take effect on direinstru right after edge N.
// Backpressure: stall holds the address and the retired count for that cycle.
module pc_fetch_unit #(
    parameter int                  PC_WIDTH  = 5,
    parameter int                  CNT_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input logic            clk,
    input logic            reset,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  br_tgt;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;
    logic [CNT_WIDTH-1:0] ret_inc;
    logic                 wrap_q, wrap_d;

    // Only the low offset bits matter: the sum wraps modulo the address space.
    assign pc_inc  = pc_q + PC_WIDTH'(1);
    assign br_tgt  = pc_inc + bus.branch_off[PC_WIDTH-1:0];
    assign ret_inc = (&ret_q) ? ret_q : ret_q + CNT_WIDTH'(1);

    // State, address, counter and wrap flag registers; reset needs no clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ret_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ret_q   <= ret_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state selection: one action per RUN cycle, halt > jump > branch > stall > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ret_d   = ret_q;
        wrap_d  = wrap_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALT;
                    ret_d   = ret_inc;
                end else if (bus.jump_en) begin
                    pc_d  = bus.jump_target;
                    ret_d = ret_inc;
                end else if (bus.branch_en) begin
                    pc_d  = br_tgt;
                    ret_d = ret_inc;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d  = pc_inc;
                    ret_d = ret_inc;
                    if (&pc_q) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                    ret_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    assign bus.direinstru = pc_q;
    assign bus.pc_plus1   = pc_inc;
    assign bus.running    = (state_q == ST_RUN);
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.wrapped    = wrap_q;
    assign bus.retired    = ret_q;

endmodule
